mem_access_unit: RTL and testbench

- MEM-stage data-memory controller between the EX/MEM pipeline register and the MEM/WB register.
- Turns the EX/MEM control and address/data fields into a request/acknowledge transaction on the external data-memory bus.
- Returns the aligned, extended load word that MEM/WB captures as its rd input.
- Raises stall, driven into the pipeline-register en_reg inputs as the inverse, while a transaction is outstanding.

---
 rtl/mem_access_unit.sv | 166 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-memory controller. Converts the EX/MEM
// load/store controls into a req/ack bus transaction, stalls the pipeline
// while the transaction is outstanding, and returns the aligned and
// extended load word for the MEM/WB register.
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] total_alu,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        stall,
    output logic        addr_err,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_t;

    state_t      state;
    logic [7:0]  counter;
    logic [1:0]  lat_lane;
    logic [1:0]  lat_size;
    logic        lat_sext;

    logic        access;
    logic        misaligned;
    logic [1:0]  lane;
    logic [3:0]  next_be;
    logic [31:0] next_wdata;
    logic [31:0] load_data;

    assign lane = total_alu[1:0];

    // Access detection and alignment check; size 11 behaves as a word
    always_comb begin
        access = MemRead | MemWrite;
        case (size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = total_alu[0];
            default: misaligned = |total_alu[1:0];
        endcase
    end

    assign addr_err = access & misaligned;

    // Stall while starting a request from IDLE and for every REQ cycle
    assign stall = (state == REQ) | ((state == IDLE) & access & ~misaligned);

    // Big-endian byte enables and lane-replicated store data for the request
    always_comb begin
        next_be    = 4'b0000;
        next_wdata = wd;
        case (size)
            2'b00: begin
                next_be    = 4'b1000 >> lane;
                next_wdata = {4{wd[7:0]}};
            end
            2'b01: begin
                next_be    = lane[1] ? 4'b0011 : 4'b1100;
                next_wdata = {2{wd[15:0]}};
            end
            default: begin
                next_be    = 4'b1111;
                next_wdata = wd;
            end
        endcase
    end

    // Select the addressed byte/half of the returned word and extend it
    always_comb begin
        load_data = mem_rdata;
        case (lat_size)
            2'b00: begin
                logic [7:0] b;
                case (lat_lane)
                    2'd0:    b = mem_rdata[31:24];
                    2'd1:    b = mem_rdata[23:16];
                    2'd2:    b = mem_rdata[15:8];
                    default: b = mem_rdata[7:0];
                endcase
                load_data = {{24{lat_sext & b[7]}}, b};
            end
            2'b01: begin
                logic [15:0] h;
                h = lat_lane[1] ? mem_rdata[15:0] : mem_rdata[31:16];
                load_data = {{16{lat_sext & h[15]}}, h};
            end
            default: load_data = mem_rdata;
        endcase
    end

    // Transaction FSM with registered bus fields, load result and error pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            counter   <= 8'd0;
            rd        <= 32'd0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_be    <= 4'b0000;
            mem_wdata <= 32'd0;
            bus_err   <= 1'b0;
            lat_lane  <= 2'd0;
            lat_size  <= 2'd0;
            lat_sext  <= 1'b0;
        end else begin
            bus_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (access && !misaligned) begin
                        mem_req   <= 1'b1;
                        mem_we    <= MemWrite;
                        mem_addr  <= {total_alu[31:2], 2'b00};
                        mem_be    <= next_be;
                        mem_wdata <= next_wdata;
                        lat_lane  <= lane;
                        lat_size  <= size;
                        lat_sext  <= sign_ext;
                        counter   <= 8'd0;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (!mem_we) begin
                            rd <= load_data;
                        end
                        state <= DONE;
                    end else if (counter == 8'(TIMEOUT - 1)) begin
                        mem_req <= 1'b0;
                        rd      <= 32'd0;
                        bus_err <= 1'b1;
                        state   <= DONE;
                    end else begin
                        counter <= counter + 8'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and randomized accesses against a
// byte-level reference model of the memory access unit.
module tb_mem_access_unit;

    localparam int TO = 15;

    logic        clk;
    logic        rst;
    logic        MemRead;
    logic        MemWrite;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] total_alu;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        stall;
    logic        addr_err;
    logic        bus_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int testsRun;
    int testsFailed;
    logic [31:0] expRd;

    mem_access_unit #(.TIMEOUT(TO)) dut (
        .clk(clk),
        .rst(rst),
        .MemRead(MemRead),
        .MemWrite(MemWrite),
        .size(size),
        .sign_ext(sign_ext),
        .total_alu(total_alu),
        .wd(wd),
        .rd(rd),
        .stall(stall),
        .addr_err(addr_err),
        .bus_err(bus_err),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_be(mem_be),
        .mem_wdata(mem_wdata),
        .mem_ack(mem_ack),
        .mem_rdata(mem_rdata)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One instruction in MEM: ackDelay = REQ cycles waited before ack; >= TO means no ack
    task automatic applyStimulus(input logic rdE, input logic wrE, input logic [1:0] sz,
                                 input logic sx, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [31:0] rdata,
                                 input int ackDelay);
        int k, n, reqCycles, stallCycles, shiftAmt;
        logic mis, acc, acked;
        logic [3:0] eBe;
        logic [31:0] eWdata, eLoad, mask;

        k = int'(addr[1:0]);
        n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        mis = (n == 2 && addr[0]) || (n == 4 && addr[1:0] != 2'b00);
        acc = rdE | wrE;

        eBe = 4'b0000;
        for (int b = k; b < k + n && b < 4; b++) eBe[3 - b] = 1'b1;
        if (n == 1)      eWdata = {4{data[7:0]}};
        else if (n == 2) eWdata = {2{data[15:0]}};
        else             eWdata = data;

        if (n == 4) begin
            eLoad = rdata;
        end else begin
            shiftAmt = 8 * (4 - k - n);
            mask = (n == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
            eLoad = (rdata >> shiftAmt) & mask;
            if (sx && eLoad[8 * n - 1]) eLoad = eLoad | ~mask;
        end

        MemRead = rdE; MemWrite = wrE; size = sz; sign_ext = sx;
        total_alu = addr; wd = data; mem_rdata = rdata; mem_ack = 1'b0;
        #1;
        checkOutput("addr_err", addr_err, acc & mis);

        if (!acc || mis) begin
            checkOutput("idle_stall", stall, 1'b0);
            mem_ack = $urandom_range(0, 1);
            tick();
            mem_ack = 1'b0;
            checkOutput("idle_req", mem_req, 1'b0);
            checkOutput("idle_rd", rd, expRd);
            return;
        end

        stallCycles = stall ? 1 : 0;
        reqCycles = (ackDelay < TO) ? ackDelay + 1 : TO;
        acked = 1'b0;
        for (int c = 0; c < TO && !acked; c++) begin
            tick();
            checkOutput("req", mem_req, 1'b1);
            checkOutput("we", mem_we, wrE);
            checkOutput("addr", mem_addr, addr & 32'hFFFF_FFFC);
            checkOutput("be", mem_be, eBe);
            checkOutput("wdata", mem_wdata, eWdata);
            if (stall) stallCycles++;
            if (c == ackDelay) begin
                mem_ack = 1'b1;
                acked = 1'b1;
            end
        end
        tick();
        mem_ack = 1'b0;
        if (acked) begin
            if (!wrE) expRd = eLoad;
        end else begin
            expRd = 32'd0;
        end
        checkOutput("stall_cycles", stallCycles, reqCycles + 1);
        checkOutput("done_stall", stall, 1'b0);
        checkOutput("done_req", mem_req, 1'b0);
        checkOutput("done_bus_err", bus_err, !acked);
        checkOutput("done_rd", rd, expRd);
        tick();
        checkOutput("idle_bus_err", bus_err, 1'b0);
        checkOutput("idle_req2", mem_req, 1'b0);
    endtask

    // Main stimulus sequence
    initial begin
        testsRun = 0; testsFailed = 0; expRd = 32'd0;
        rst = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; size = 2'b00; sign_ext = 1'b0;
        total_alu = 32'd0; wd = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
        #12;
        checkOutput("rst_rd", rd, 32'd0);
        checkOutput("rst_req", mem_req, 1'b0);
        checkOutput("rst_be", mem_be, 4'b0000);
        checkOutput("rst_addr", mem_addr, 32'd0);
        checkOutput("rst_stall", stall, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        applyStimulus(1, 0, 2'b10, 0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0);
        applyStimulus(1, 0, 2'b00, 1, 32'h0000_0103, 32'h0, 32'h1234_56F0, 0);
        applyStimulus(1, 0, 2'b00, 0, 32'h0000_0103, 32'h0, 32'h1234_56F0, 0);
        applyStimulus(0, 1, 2'b01, 0, 32'h0000_0202, 32'h0000_ABCD, 32'h0, 3);
        applyStimulus(1, 0, 2'b10, 0, 32'h0000_0101, 32'h0, 32'h0, 0);
        applyStimulus(1, 0, 2'b01, 1, 32'h0000_0012, 32'h0, 32'h8001_7FFE, TO - 1);
        applyStimulus(1, 0, 2'b10, 0, 32'h0000_0040, 32'h0, 32'h5555_AAAA, TO + 5);

        for (int i = 0; i < 60; i++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = (size == 2'b00) ? a[1:0] : 2'b00;
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                          a, $urandom, $urandom, int'($urandom_range(0, TO + 1)));
        end

        // Reset in the middle of an outstanding load
        MemRead = 1'b1; MemWrite = 1'b0; size = 2'b10; total_alu = 32'h0000_0300;
        mem_rdata = 32'hCAFE_F00D; mem_ack = 1'b0;
        tick();
        tick();
        checkOutput("pre_rst_req", mem_req, 1'b1);
        rst = 1'b0;
        #1;
        checkOutput("async_rst_req", mem_req, 1'b0);
        checkOutput("async_rst_rd", rd, 32'd0);
        expRd = 32'd0;
        mem_ack = 1'b1;
        tick();
        MemRead = 1'b0;
        rst = 1'b1;
        tick();
        mem_ack = 1'b0;
        checkOutput("post_rst_req", mem_req, 1'b0);
        checkOutput("post_rst_rd", rd, 32'd0);
        applyStimulus(1, 0, 2'b01, 0, 32'h0000_0300, 32'h0, 32'hCAFE_F00D, 1);

        MemRead = 1'b0; MemWrite = 1'b0;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
